copytoken_receiver: RTL and testbench

Per-BRAM receiver at the far end of the copy-command path. It accepts one copy command per cycle from its copytoken_selector and checks the requested bytes against a byte-written scoreboard for that BRAM. Satisfiable commands go to a resolved FIFO for the ram_module read port. Unsatisfiable commands go back to the selector through the unsolved FIFO. It also drives the selector's `stop` backpressure.

---
 rtl/copytoken_receiver.sv | 171 +++++++++++++++++
 tb/tb_copytoken_receiver.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/copytoken_receiver.sv
// copytoken_receiver: checks copy commands against a per-BRAM byte-written scoreboard and routes them
// to a resolved or an unsolved FWFT FIFO. Define COPYTOKEN_WR_BYPASS_EN for same-cycle write forwarding.

module copytoken_fifo #(
    parameter int WIDTH = 33,
    parameter int LOG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic [LOG:0]     count
);
    localparam int DEPTH = 1 << LOG;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LOG:0]     wptr;
    logic [LOG:0]     rptr;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign count   = wptr - rptr;
    assign empty   = (count == '0);
    assign full    = count[LOG];
    assign do_pop  = pop && !empty;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rptr[LOG-1:0]];

    // NOTE: storage is deliberately not reset; only the pointers need a known state, and dout is gated while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[LOG-1:0]] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + (LOG+1)'(1);
            if (do_pop)  rptr <= rptr + (LOG+1)'(1);
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !do_pop));
endmodule

module copytoken_receiver #(
    parameter int ADDR_W      = 9,
    parameter int FIFO_LOG    = 4,
    parameter int STOP_MARGIN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address_in,
    input  logic [7:0]        bvalid_in,
    input  logic [15:0]       offset_in,
    input  logic              valid_in,
    output logic              stop,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_address,
    input  logic [7:0]        wr_bvalid,
    input  logic              sb_clear,
    output logic [ADDR_W+23:0] unsolved_out,
    output logic              unsolved_valid_out,
    input  logic              unsolved_rd_in,
    output logic [ADDR_W-1:0] res_address_out,
    output logic [7:0]        res_bvalid_out,
    output logic [15:0]       res_offset_out,
    output logic              res_valid_out,
    input  logic              res_ready_in,
    output logic              idle_out
);
    localparam int CMD_W = ADDR_W + 24;
    localparam int LINES = 1 << ADDR_W;
    localparam int DEPTH = 1 << FIFO_LOG;

    // The margin must absorb the stop register, the selector's output register and stage 1.
    if (STOP_MARGIN < 3) begin : g_bad_margin
        $error("STOP_MARGIN must be at least 3");
    end

    logic [7:0]       sb [LINES];
    logic [7:0]       fwd;
    logic             hit;
    logic             s1_valid;
    logic             s1_hit;
    logic [CMD_W-1:0] s1_cmd;
    logic [CMD_W-1:0] res_dout;
    logic             res_empty;
    logic             uns_empty;
    logic [FIFO_LOG:0] res_count;
    logic [FIFO_LOG:0] uns_count;
    int               res_slack;
    int               uns_slack;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        fwd = '0;
`ifdef COPYTOKEN_WR_BYPASS_EN
        if (wr_valid && (wr_address == address_in)) fwd = wr_bvalid;
`endif
        hit = (((sb[address_in] | fwd) & bvalid_in) == bvalid_in);
    end

    // Clear takes priority over a write landing in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LINES; i++) sb[i] <= '0;
        end else if (sb_clear) begin
            for (int i = 0; i < LINES; i++) sb[i] <= '0;
        end else if (wr_valid) begin
            sb[wr_address] <= sb[wr_address] | wr_bvalid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_hit   <= 1'b0;
            s1_cmd   <= '0;
        end else begin
            s1_valid <= valid_in;
            s1_hit   <= hit;
            s1_cmd   <= {address_in, bvalid_in, offset_in};
        end
    end

    copytoken_fifo #(.WIDTH(CMD_W), .LOG(FIFO_LOG)) u_res_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s1_valid && s1_hit),
        .din   (s1_cmd),
        .pop   (res_ready_in),
        .dout  (res_dout),
        .empty (res_empty),
        .count (res_count)
    );

    copytoken_fifo #(.WIDTH(CMD_W), .LOG(FIFO_LOG)) u_uns_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s1_valid && !s1_hit),
        .din   (s1_cmd),
        .pop   (unsolved_rd_in),
        .dout  (unsolved_out),
        .empty (uns_empty),
        .count (uns_count)
    );

    // Stage 1 may land in either FIFO, so it is charged against both.
    always_comb begin
        res_slack = DEPTH - int'(res_count) - int'(s1_valid);
        uns_slack = DEPTH - int'(uns_count) - int'(s1_valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stop <= 1'b0;
        else     stop <= (res_slack < STOP_MARGIN) || (uns_slack < STOP_MARGIN);
    end

    assign {res_address_out, res_bvalid_out, res_offset_out} = res_dout;
    assign res_valid_out      = !res_empty;
    assign unsolved_valid_out = !uns_empty;
    assign idle_out           = res_empty && uns_empty && !s1_valid;
endmodule

// File: tb/tb_copytoken_receiver.sv
// Scoreboard bench for copytoken_receiver: a byte-level reference model predicts the routing of each
// command, and a monitor process checks every FIFO pop against the predicted queues.
`timescale 1ns/1ps

module tb_copytoken_receiver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  address_in = '0;
    logic [7:0]  bvalid_in = '0;
    logic [15:0] offset_in = '0;
    logic        valid_in = 1'b0;
    logic        stop;
    logic        wr_valid = 1'b0;
    logic [8:0]  wr_address = '0;
    logic [7:0]  wr_bvalid = '0;
    logic        sb_clear = 1'b0;
    logic [32:0] unsolved_out;
    logic        unsolved_valid_out;
    logic        unsolved_rd_in;
    logic [8:0]  res_address_out;
    logic [7:0]  res_bvalid_out;
    logic [15:0] res_offset_out;
    logic        res_valid_out;
    logic        res_ready_in;
    logic        idle_out;

    logic hold = 1'b1;
    logic dir_rd = 1'b0, dir_ready = 1'b0;
    logic mon_rd = 1'b0, mon_ready = 1'b0;
    assign unsolved_rd_in = hold ? dir_rd : mon_rd;
    assign res_ready_in   = hold ? dir_ready : mon_ready;

    int n_cmp = 0;
    int n_bad = 0;
    logic [32:0] res_q[$];
    logic [32:0] uns_q[$];
    logic [7:0]  sb_m [512];

    copytoken_receiver #(.ADDR_W(9), .FIFO_LOG(4), .STOP_MARGIN(4)) dut (
        .clk(clk), .rst(rst),
        .address_in(address_in), .bvalid_in(bvalid_in), .offset_in(offset_in), .valid_in(valid_in),
        .stop(stop),
        .wr_valid(wr_valid), .wr_address(wr_address), .wr_bvalid(wr_bvalid), .sb_clear(sb_clear),
        .unsolved_out(unsolved_out), .unsolved_valid_out(unsolved_valid_out), .unsolved_rd_in(unsolved_rd_in),
        .res_address_out(res_address_out), .res_bvalid_out(res_bvalid_out), .res_offset_out(res_offset_out),
        .res_valid_out(res_valid_out), .res_ready_in(res_ready_in),
        .idle_out(idle_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One input cycle: predict the routing of the command, update the model, clock it in.
    task automatic step(input bit cmd, input int a, input logic [7:0] bv, input logic [15:0] off,
                        input bit wr, input int wa, input logic [7:0] wm, input bit clr);
        logic [7:0] fwd;
        bit hit;
        address_in = 9'(a);
        bvalid_in  = bv;
        offset_in  = off;
        valid_in   = cmd;
        wr_valid   = wr;
        wr_address = 9'(wa);
        wr_bvalid  = wm;
        sb_clear   = clr;
        if (cmd) begin
            fwd = 8'h00;
`ifdef COPYTOKEN_WR_BYPASS_EN
            if (wr && (wa == a)) fwd = wm;
`endif
            hit = 1'b1;
            for (int i = 0; i < 8; i++)
                if (bv[i] && !sb_m[a][i] && !fwd[i]) hit = 1'b0;
            if (hit) res_q.push_back({9'(a), bv, off});
            else     uns_q.push_back({9'(a), bv, off});
        end
        if (clr)     foreach (sb_m[i]) sb_m[i] = 8'h00;
        else if (wr) sb_m[wa] = sb_m[wa] | wm;
        tick();
        valid_in = 1'b0;
        wr_valid = 1'b0;
        sb_clear = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        hold = 1'b0;
        while ((res_q.size() != 0 || uns_q.size() != 0 || !idle_out) && n < 300) begin
            tick();
            n++;
        end
        check({name, "_res_left"}, 64'(res_q.size()), 0);
        check({name, "_uns_left"}, 64'(uns_q.size()), 0);
        check({name, "_idle"}, idle_out, 1);
        tick();
        check({name, "_stop"}, stop, 0);
    endtask

    // Monitor: owns the ready/rd strobes outside directed sections and checks every pop.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (hold) begin
                mon_rd    = 1'b0;
                mon_ready = 1'b0;
            end else begin
                mon_ready = ($urandom_range(0, 3) != 0);
                mon_rd    = ($urandom_range(0, 2) != 0);
                if (res_valid_out && mon_ready) begin
                    if (res_q.size() == 0) check("res_extra", res_valid_out, 0);
                    else check("res_head", {res_address_out, res_bvalid_out, res_offset_out}, res_q.pop_front());
                end
                if (unsolved_valid_out && mon_rd) begin
                    if (uns_q.size() == 0) check("uns_extra", unsolved_valid_out, 0);
                    else check("uns_head", unsolved_out, uns_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev;
        bit saw_stop;
        bit cmd, clr, wr;
        int a, wa;
        foreach (sb_m[i]) sb_m[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stop", stop, 0);
        check("rst_res_valid", res_valid_out, 0);
        check("rst_uns_valid", unsolved_valid_out, 0);
        check("rst_idle", idle_out, 1);
        check("rst_res_data", {res_address_out, res_bvalid_out, res_offset_out}, 0);
        check("rst_uns_data", unsolved_out, 0);
        rst = 1'b0;
        tick();

        // Write then hit: resolved head visible two cycles after the command.
        step(0, 0, 8'h00, 16'h0000, 1, 5, 8'hFF, 0);
        step(1, 5, 8'h0F, 16'h0010, 0, 0, 8'h00, 0);
        check("t1_latency", res_valid_out, 0);
        tick();
        check("t1_res_valid", res_valid_out, 1);
        check("t1_res_head", {res_address_out, res_bvalid_out, res_offset_out}, {9'd5, 8'h0F, 16'h0010});
        check("t1_uns_valid", unsolved_valid_out, 0);
        drain("t1");

        // Miss goes to unsolved; a single rd pulse empties it.
        hold = 1'b1;
        step(1, 7, 8'h01, 16'hBEEF, 0, 0, 8'h00, 0);
        check("t2_latency", unsolved_valid_out, 0);
        tick();
        check("t2_uns_valid", unsolved_valid_out, 1);
        check("t2_uns_head", unsolved_out, {9'd7, 8'h01, 16'hBEEF});
        dir_rd = 1'b1;
        tick();
        dir_rd = 1'b0;
        void'(uns_q.pop_front());
        check("t2_uns_popped", unsolved_valid_out, 0);

        // Write coinciding with the command that needs it.
        step(1, 3, 8'h0C, 16'h0033, 1, 3, 8'h0F, 0);
        tick();
`ifdef COPYTOKEN_WR_BYPASS_EN
        check("t3_res_valid", res_valid_out, 1);
        check("t3_uns_valid", unsolved_valid_out, 0);
`else
        check("t3_res_valid", res_valid_out, 0);
        check("t3_uns_valid", unsolved_valid_out, 1);
`endif
        drain("t3");

        // Clear beats a same-cycle write.
        hold = 1'b1;
        step(0, 0, 8'h00, 16'h0000, 1, 2, 8'hFF, 1);
        step(1, 2, 8'h01, 16'h0222, 0, 0, 8'h00, 0);
        tick();
        check("t4_uns_valid", unsolved_valid_out, 1);
        check("t4_res_valid", res_valid_out, 0);
        drain("t4");

        // Stream hits with the resolved side blocked; selector obeys stop immediately.
        hold = 1'b1;
        step(0, 0, 8'h00, 16'h0000, 1, 10, 8'hFF, 0);
        prev = res_q.size();
        saw_stop = 1'b0;
        for (int i = 0; i < 24; i++) begin
            check("stream_stop", stop, 64'(prev >= 13));
            prev = res_q.size();
            if (stop) saw_stop = 1'b1;
            step(!stop, 10, 8'($urandom), 16'(i), 0, 0, 8'h00, 0);
        end
        check("stream_stop_seen", saw_stop, 1);
        check("stream_uns_valid", unsolved_valid_out, 0);
        drain("stream");

        // Randomised traffic with concurrent writes, clears and random pops.
        hold = 1'b0;
        for (int i = 0; i < 400; i++) begin
            cmd = !stop && ($urandom_range(0, 4) != 0);
            clr = ($urandom_range(0, 63) == 0);
            if (clr) cmd = 1'b0;
            a  = $urandom_range(0, 15);
            wr = $urandom_range(0, 1) != 0;
            wa = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, 15);
            step(cmd, a, ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
                 16'($urandom), wr, wa, 8'($urandom) & 8'($urandom), clr);
        end
        drain("rand");

        // Asynchronous reset with both FIFOs half full.
        hold = 1'b1;
        step(0, 0, 8'h00, 16'h0000, 1, 20, 8'hFF, 0);
        for (int i = 0; i < 16; i++)
            step(1, (i % 2 == 0) ? 20 : 21, 8'h01, 16'(i), 0, 0, 8'h00, 0);
        tick();
        check("t6_res_filled", res_valid_out, 1);
        check("t6_uns_filled", unsolved_valid_out, 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("t6_res_valid", res_valid_out, 0);
        check("t6_uns_valid", unsolved_valid_out, 0);
        check("t6_idle", idle_out, 1);
        check("t6_stop", stop, 0);
        check("t6_uns_data", unsolved_out, 0);
        res_q.delete();
        uns_q.delete();
        foreach (sb_m[i]) sb_m[i] = 8'h00;
        tick();
        rst = 1'b0;
        tick();
        // Scoreboard was wiped by reset, so addr 20 now misses.
        step(1, 20, 8'h01, 16'h0F0F, 0, 0, 8'h00, 0);
        tick();
        check("t6_post_uns", unsolved_valid_out, 1);
        drain("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
